// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: write-back, link, read-bypass and RF write-port signals of the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DEPTH = 2
);
    logic                             wb_valid;
    logic [4:0]                       wb_reg;
    logic [63:0]                      wb_data;
    logic                             link_valid;
    logic [63:0]                      link_data;
    logic [4:0]                       rd1_addr;
    logic [4:0]                       rd2_addr;
    logic                             rf_we;
    logic [4:0]                       rf_wreg;
    logic [63:0]                      rf_wdata;
    logic                             byp1_hit;
    logic                             byp2_hit;
    logic [63:0]                      byp1_data;
    logic [63:0]                      byp2_data;
    logic                             stall_req;
    logic [$clog2(DEPTH+1)-1:0]       count;

    modport master (
        output wb_valid, wb_reg, wb_data, link_valid, link_data, rd1_addr, rd2_addr,
        input  rf_we, rf_wreg, rf_wdata, byp1_hit, byp2_hit, byp1_data, byp2_data, stall_req, count
    );
    modport slave (
        input  wb_valid, wb_reg, wb_data, link_valid, link_data, rd1_addr, rd2_addr,
        output rf_we, rf_wreg, rf_wdata, byp1_hit, byp2_hit, byp1_data, byp2_data, stall_req, count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the RF write port between WB and FIFO-queued BL link writes.
// REGFILE_WRARB_BYPASS_EN enables link-data read bypass; without it decode stalls on pending link reads.
module regfile_write_arbiter #(
    parameter int DEPTH    = 2,
    parameter int LINK_REG = 30,
    parameter int AGE_KILL = 3
) (
    input logic                    clock,
    input logic                    reset,
    regfile_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(AGE_KILL+1);
    localparam logic [4:0]    LR = 5'(LINK_REG);
    localparam logic [AW-1:0] AK = AW'(AGE_KILL);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [CW-1:0] count_q, count_d, tail;
    logic          vld_q [DEPTH];
    logic          vld_d [DEPTH];
    logic [AW-1:0] age_q [DEPTH];
    logic [AW-1:0] age_d [DEPTH];
    logic [63:0]   dat_q [DEPTH];
    logic [63:0]   dat_d [DEPTH];
    logic          eff_wb, kill_en, pop, head_wr, pass, any_vld, stall, push;

    always_comb begin
        eff_wb  = reset && bus.wb_valid && bus.wb_reg != 5'd31;
        kill_en = eff_wb && bus.wb_reg == LR;
        pop     = !eff_wb && count_q != '0;
        head_wr = pop && vld_q[0];
        pass    = reset && !eff_wb && count_q == '0 && bus.link_valid;
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_vld = any_vld | vld_q[i];
`ifdef REGFILE_WRARB_BYPASS_EN
        stall          = count_q == FULL && eff_wb;
        bus.byp1_hit   = 1'b0;
        bus.byp2_hit   = 1'b0;
        bus.byp1_data  = '0;
        bus.byp2_data  = '0;
        // Later slots are younger, so the last match wins.
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && !(kill_en && age_q[i] == AK)) begin
                if (bus.rd1_addr == LR) begin
                    bus.byp1_hit  = 1'b1;
                    bus.byp1_data = dat_q[i];
                end
                if (bus.rd2_addr == LR) begin
                    bus.byp2_hit  = 1'b1;
                    bus.byp2_data = dat_q[i];
                end
            end
        end
`else
        stall         = (count_q == FULL && eff_wb) || ((bus.rd1_addr == LR || bus.rd2_addr == LR) && any_vld);
        bus.byp1_hit  = 1'b0;
        bus.byp2_hit  = 1'b0;
        bus.byp1_data = '0;
        bus.byp2_data = '0;
`endif
        push = reset && bus.link_valid && !stall && !pass && !(count_q == FULL && !pop);
        tail = count_q - CW'(pop);
        for (int i = 0; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i] && !(kill_en && age_q[i] == AK);
            age_d[i] = age_q[i] == AK ? AK : age_q[i] + AW'(1);
            dat_d[i] = dat_q[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                vld_d[i] = vld_d[i+1];
                age_d[i] = age_d[i+1];
                dat_d[i] = dat_d[i+1];
            end
            vld_d[DEPTH-1] = 1'b0;
            age_d[DEPTH-1] = '0;
            dat_d[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && tail == CW'(i)) begin
                vld_d[i] = 1'b1;
                age_d[i] = '0;
                dat_d[i] = bus.link_data;
            end
        end
        count_d       = tail + CW'(push);
        bus.rf_we     = eff_wb || head_wr || pass;
        bus.rf_wreg   = eff_wb ? bus.wb_reg : (head_wr || pass) ? LR : 5'd0;
        bus.rf_wdata  = eff_wb ? bus.wb_data : head_wr ? dat_q[0] : pass ? bus.link_data : 64'd0;
        bus.stall_req = stall;
        bus.count     = count_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0;
                age_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            vld_q   <= vld_d;
            age_q   <= age_d;
            dat_q   <= dat_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of WB priority, link FIFO, stall, kill and bypass behaviour.
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    regfile_write_arbiter_if #(.DEPTH(2)) bus ();

    regfile_write_arbiter #(.DEPTH(2), .LINK_REG(30), .AGE_KILL(3)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wv, input logic [4:0] wr, input logic [63:0] wd,
                         input logic lv, input logic [63:0] ld);
        bus.wb_valid   = wv;
        bus.wb_reg     = wr;
        bus.wb_data    = wd;
        bus.link_valid = lv;
        bus.link_data  = ld;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] wr, input logic [63:0] wd);
        chk({tag, "_we"}, 64'(bus.rf_we), 64'(we));
        chk({tag, "_wreg"}, 64'(bus.rf_wreg), 64'(wr));
        chk({tag, "_wdata"}, bus.rf_wdata, wd);
    endtask

    initial begin
        bus.rd1_addr = 5'd0;
        bus.rd2_addr = 5'd0;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        #2;
        chk_wr("rst", 1'b0, 5'd0, 64'd0);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_stall", 64'(bus.stall_req), 64'd0);
        chk("rst_byp1", 64'(bus.byp1_hit), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        drive(1'b0, 5'd0, 64'd0, 1'b1, 64'h40);
        chk_wr("pass", 1'b1, 5'd30, 64'h40);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        chk("pass_count", 64'(bus.count), 64'd0);

        drive(1'b1, 5'd5, 64'hA, 1'b1, 64'h100);
        chk_wr("wb1", 1'b1, 5'd5, 64'hA);
        chk("wb1_stall", 64'(bus.stall_req), 64'd0);
        step();
        drive(1'b1, 5'd5, 64'hB, 1'b1, 64'h104);
        chk("wb2_count", 64'(bus.count), 64'd1);
        chk("wb2_stall", 64'(bus.stall_req), 64'd0);
        step();
        drive(1'b1, 5'd5, 64'hC, 1'b1, 64'h108);
        chk("wb3_count", 64'(bus.count), 64'd2);
        chk("wb3_stall", 64'(bus.stall_req), 64'd1);
        chk_wr("wb3", 1'b1, 5'd5, 64'hC);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        chk("drop_count", 64'(bus.count), 64'd2);
        chk_wr("drain1", 1'b1, 5'd30, 64'h100);
        step();
        chk_wr("drain2", 1'b1, 5'd30, 64'h104);
        chk("drain2_count", 64'(bus.count), 64'd1);
        step();
        chk_wr("drained", 1'b0, 5'd0, 64'd0);
        chk("drained_count", 64'(bus.count), 64'd0);

        drive(1'b1, 5'd31, 64'h55, 1'b1, 64'h44);
        chk_wr("x31", 1'b1, 5'd30, 64'h44);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        chk("x31_count", 64'(bus.count), 64'd0);

        drive(1'b1, 5'd5, 64'h1, 1'b1, 64'h200);
        step();
        drive(1'b1, 5'd5, 64'h2, 1'b0, 64'd0);
        step();
        step();
        step();
        drive(1'b1, 5'd30, 64'h7, 1'b0, 64'd0);
        chk_wr("kill_wb", 1'b1, 5'd30, 64'h7);
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        chk("kill_count", 64'(bus.count), 64'd1);
        chk_wr("kill_pop", 1'b0, 5'd0, 64'd0);
        step();
        chk("kill_empty", 64'(bus.count), 64'd0);
        chk_wr("kill_none", 1'b0, 5'd0, 64'd0);

        drive(1'b1, 5'd5, 64'h3, 1'b1, 64'h300);
        step();
        bus.rd2_addr = 5'd30;
        drive(1'b1, 5'd5, 64'h4, 1'b0, 64'd0);
        chk_wr("byp_wb", 1'b1, 5'd5, 64'h4);
`ifdef REGFILE_WRARB_BYPASS_EN
        chk("byp_hit", 64'(bus.byp2_hit), 64'd1);
        chk("byp_data", bus.byp2_data, 64'h300);
        chk("byp_stall", 64'(bus.stall_req), 64'd0);
`else
        chk("byp_hit", 64'(bus.byp2_hit), 64'd0);
        chk("byp_data", bus.byp2_data, 64'd0);
        chk("byp_stall", 64'(bus.stall_req), 64'd1);
`endif
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b1, 64'h3F0);
        chk_wr("byp_drain", 1'b1, 5'd30, 64'h300);
`ifdef REGFILE_WRARB_BYPASS_EN
        chk("byp_drain_stall", 64'(bus.stall_req), 64'd0);
`else
        chk("byp_drain_stall", 64'(bus.stall_req), 64'd1);
`endif
        step();
        drive(1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
`ifdef REGFILE_WRARB_BYPASS_EN
        chk("byp_after_count", 64'(bus.count), 64'd1);
        chk_wr("byp_after", 1'b1, 5'd30, 64'h3F0);
        step();
`else
        chk("byp_after_count", 64'(bus.count), 64'd0);
        chk("byp_after_stall", 64'(bus.stall_req), 64'd0);
`endif
        chk("byp_clear", 64'(bus.byp2_hit), 64'd0);
        bus.rd2_addr = 5'd0;

        drive(1'b1, 5'd5, 64'h8, 1'b1, 64'h500);
        step();
        drive(1'b1, 5'd5, 64'h9, 1'b1, 64'h504);
        step();
        bus.rd1_addr = 5'd30;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 64'd0);
        chk("mid_count", 64'(bus.count), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("mrst_count", 64'(bus.count), 64'd0);
        chk("mrst_we", 64'(bus.rf_we), 64'd0);
        chk("mrst_byp1", 64'(bus.byp1_hit), 64'd0);
        chk("mrst_stall", 64'(bus.stall_req), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_we", 64'(bus.rf_we), 64'd0);
        chk("post_count", 64'(bus.count), 64'd0);
        step();
        chk("post2_we", 64'(bus.rf_we), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between the MEM/WB write-back path and branch-and-link (BL) link writes produced in the decode stage. Write-back always wins the port. Link writes that lose arbitration wait in a small FIFO and drain on free cycles. The block also supplies read bypass for pending link data, and raises a stall toward decode when it cannot accept another link write.

## Interface
Parameters:
- DEPTH, 2, link-write FIFO entries (≥1).
- LINK_REG, 30, destination register of every link write.
- AGE_KILL, 3, age in cycles at which a pending entry is older than the instruction in WB.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; clears all state.
- wb_valid  in  1  MEM/WB requests a register write.
- wb_reg  in  5  MEM/WB destination register.
- wb_data  in  64  MEM/WB write data.
- link_valid  in  1  decode issues a BL link write this cycle.
- link_data  in  64  return address to write to LINK_REG.
- rd1_addr, rd2_addr  in  5  decode read addresses.
- rf_we  out  1  register-file write enable.
- rf_wreg  out  5  register-file write address.
- rf_wdata  out  64  register-file write data.
- byp1_hit, byp2_hit  out  1  read N matches pending link data.
- byp1_data, byp2_data  out  64  bypass data.
- stall_req  out  1  decode must hold; link_valid is ignored this cycle.
- count  out  $clog2(DEPTH+1)  valid FIFO occupancy.

## Operation
- Effective WB request: wb_valid && wb_reg != 31. A write to X31 never uses the port.
- Port priority, evaluated each cycle:
  1. Effective WB request.
  2. Valid FIFO head: dequeue it and write LINK_REG with its data.
  3. Incoming link_valid with an empty FIFO: pass-through write, not enqueued.
- Enqueue: a link_valid that does not get the port is pushed at the tail, age 0, if a slot is free after this cycle's dequeue.
- stall_req = (count == DEPTH) && effective WB request. In that state no slot can free, so any link_valid that cycle is dropped and decode re-issues it.
- Age: each entry's age increments every cycle and saturates at AGE_KILL.
- Kill rule: if the effective WB request has wb_reg == LINK_REG, every valid entry with age == AGE_KILL is invalidated at that edge. The WB instruction is younger than the BL that produced the entry. Entries with age < AGE_KILL are retained, because they are younger than the WB instruction and must land after it.
- Invalid head: popped without writing, and the port is idle that cycle. The FIFO keeps order; killed slots stay in place until popped.
- Bypass: rdN_addr == LINK_REG and at least one valid entry not killed this cycle → bypN_hit = 1, bypN_data = data of the youngest such entry. Otherwise hit = 0 and data = 0. A pass-through write is not bypassed; the register file handles it.
- Reset mid-operation: all entries discarded and pending link writes are lost.

## Timing
- Reset values: rf_we 0, rf_wreg 0, rf_wdata 0, byp*_hit 0, byp*_data 0, stall_req 0, count 0.
- rf_*, byp*, and stall_req are combinational from the inputs and FIFO state. The register file commits at the same rising edge: 0-cycle latency for WB and pass-through writes.
- An enqueued entry is written at the earliest edge after enqueue where no effective WB request exists and it is at the head.
- Simultaneous enqueue and dequeue at count == DEPTH is permitted.
- count and ages update at the rising edge only.

## Configuration
- REGFILE_WRARB_BYPASS_EN defined: bypass logic as described.
- Undefined:
  - byp*_hit and byp*_data are tied 0.
  - stall_req is additionally asserted whenever rd1_addr or rd2_addr == LINK_REG and a valid entry exists, until the FIFO has no valid entries.

## Test plan
- Reset with reset=0 mid-stream (count=2) → count 0, rf_we 0, byp hits 0 immediately; with reset=1 and no requests, no writes.
- link_valid, link_data=0x40, FIFO empty, wb_valid=0 → same cycle rf_we=1, rf_wreg=30, rf_wdata=0x40; count stays 0.
- wb_valid to X5 for 3 cycles while link 0x100 then 0x104 arrive →
  - count reaches 2 and stall_req=1 on the third cycle; the third link is dropped.
  - After WB stops, X30 receives 0x100 then 0x104 on consecutive cycles.
- Entry 0x200 pending for 3 cycles (ages to AGE_KILL), then wb_valid wb_reg=30 wb_data=0x7 → entry killed, X30=7 final, no later write of 0x200.
- Pending entry 0x300, rd2_addr=30 → byp2_hit=1, byp2_data=0x300 (with REGFILE_WRARB_BYPASS_EN); without it, stall_req=1 until the entry drains.
